// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Stall/flush controller for the 5-stage core. Resolves load-use
//             hazards, taken-branch flushes and multi-cycle data-memory waits
//             (with a sticky timeout trap), and keeps saturating stall/flush
//             cycle counters.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdE,
   input  logic             LoadE,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   input  logic             perf_clr,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // The wait counter only has to reach TIMEOUT-1.
   localparam int                    c_WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]      c_CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t              r_state;
   logic [c_WAIT_W-1:0] r_wait_cnt;
   logic                r_mem_timeout;
   logic [CNT_W-1:0]    r_stall_cnt;
   logic [CNT_W-1:0]    r_flush_cnt;

   logic w_mem_stall;
   logic w_lw_stall;
   logic w_stall_f;
   logic w_stall_d;
   logic w_stall_e;
   logic w_stall_m;
   logic w_flush_d;
   logic w_flush_e;
   logic w_flush_w;
   logic w_branch_taken;

   // Memory freeze is visible in the same cycle the unfinished access is seen.
   assign w_mem_stall = ((r_state == ST_IDLE) && MemReqM && !MemReadyM) ||
                        ((r_state == ST_WAIT) && !MemReadyM) ||
                        (r_state == ST_ERR);

   assign w_lw_stall  = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

   // Stall/flush decode; memory freeze dominates, then branch, then load-use.
   // Everything is forced low while reset is held so the pipe sees no stray enables.
   always_comb begin
      w_stall_f = 1'b0;
      w_stall_d = 1'b0;
      w_stall_e = 1'b0;
      w_stall_m = 1'b0;
      w_flush_d = 1'b0;
      w_flush_e = 1'b0;
      w_flush_w = 1'b0;
      if (!reset) begin
         if (w_mem_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
         end else begin
            w_stall_f = w_lw_stall && !PCSrcE;
            w_stall_d = w_lw_stall && !PCSrcE;
            w_flush_d = PCSrcE;
            w_flush_e = PCSrcE || w_lw_stall;
         end
      end
   end

   assign w_branch_taken = !reset && !w_mem_stall && PCSrcE;

   // Memory-wait FSM with timeout trap; ERR is left only through reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (MemReqM && !MemReadyM) begin
                  r_state    <= ST_WAIT;
                  r_wait_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (MemReadyM) begin
                  r_state <= ST_IDLE;
               end else if (r_wait_cnt == c_WAIT_LAST) begin
                  r_state       <= ST_ERR;
                  r_mem_timeout <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            ST_ERR: begin
               r_mem_timeout <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Saturating performance counters; clear wins over increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (perf_clr) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_f && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_branch_taken && (r_flush_cnt != c_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign StallF      = w_stall_f;
   assign StallD      = w_stall_d;
   assign StallE      = w_stall_e;
   assign StallM      = w_stall_m;
   assign FlushD      = w_flush_d;
   assign FlushE      = w_flush_e;
   assign FlushW      = w_flush_w;
   assign mem_timeout = r_mem_timeout;
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire
